// File: rtl/aha_clk_seq_pkg.sv
// Shared types and helpers for the clock-switch sequencer.
package aha_clk_seq_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GATE_WAIT = 2'd1,
        SEL_WAIT  = 2'd2
    } seq_state_t;

    localparam int DEFAULT_MAX_SEL = 5;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/aha_settle_timer.sv
// Loadable down-counter that parks at zero and flags it.
module aha_settle_timer
    import aha_clk_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 64
) (
    input  logic clk,
    input  logic srst,
    input  logic load,
    input  logic en,
    output logic zero
);

    localparam int CW = clog2(SETTLE_CYCLES + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = CW'(SETTLE_CYCLES - 1);
        end else if (en && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/aha_clock_switch_sequencer.sv
// Glitch-safe divider switch: gate, settle, change select, settle, restore gate.
module aha_clock_switch_sequencer
    import aha_clk_seq_pkg::*;
#(
    parameter int SEL_WIDTH     = 3,
    parameter int MAX_SEL       = DEFAULT_MAX_SEL,
    parameter int SETTLE_CYCLES = 64,
    parameter int RESET_SELECT  = 0,
    parameter bit RESET_GATE    = 1'b1
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 REQ_VALID,
    output logic                 REQ_READY,
    input  logic [SEL_WIDTH-1:0] REQ_SELECT,
    input  logic                 REQ_GATE,
    output logic [SEL_WIDTH-1:0] CLK_SELECT,
    output logic                 CLK_GATE,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 REQ_ERR
);

    seq_state_t state_q, state_d;
    logic [SEL_WIDTH-1:0] sel_q, sel_d;
    logic [SEL_WIDTH-1:0] clk_select_q, clk_select_d;
    logic gate_q, gate_d;
    logic err_q, err_d;
    logic clk_gate_q, clk_gate_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic req_err_q, req_err_d;

    logic                 timer_load;
    logic                 timer_en;
    logic                 timer_zero;
    logic                 clamp_err;
    logic [SEL_WIDTH-1:0] sel_clamped;

    aha_settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_timer (
        .clk (CLK),
        .srst(RESET),
        .load(timer_load),
        .en  (timer_en),
        .zero(timer_zero)
    );

    assign clamp_err   = (REQ_SELECT > SEL_WIDTH'(MAX_SEL));
    assign sel_clamped = clamp_err ? SEL_WIDTH'(MAX_SEL) : REQ_SELECT;

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        gate_d       = gate_q;
        err_d        = err_q;
        clk_select_d = clk_select_q;
        clk_gate_d   = clk_gate_q;
        done_d       = 1'b0;
        req_err_d    = 1'b0;
        timer_load   = 1'b0;
        timer_en     = 1'b0;
        case (state_q)
            IDLE: begin
                if (REQ_VALID) begin
                    sel_d  = sel_clamped;
                    gate_d = REQ_GATE;
                    err_d  = clamp_err;
                    // Same divider: no select change, so the gate can move immediately.
                    if (sel_clamped == clk_select_q) begin
                        clk_gate_d = REQ_GATE;
                        done_d     = 1'b1;
                        req_err_d  = clamp_err;
                    end else begin
                        clk_gate_d = 1'b1;
                        timer_load = 1'b1;
                        state_d    = GATE_WAIT;
                    end
                end
            end
            GATE_WAIT: begin
                if (timer_zero) begin
                    clk_select_d = sel_q;
                    timer_load   = 1'b1;
                    state_d      = SEL_WAIT;
                end else begin
                    timer_en = 1'b1;
                end
            end
            SEL_WAIT: begin
                if (timer_zero) begin
                    clk_gate_d = gate_q;
                    done_d     = 1'b1;
                    req_err_d  = err_q;
                    state_d    = IDLE;
                end else begin
                    timer_en = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= IDLE;
            sel_q        <= SEL_WIDTH'(RESET_SELECT);
            gate_q       <= RESET_GATE;
            err_q        <= 1'b0;
            clk_select_q <= SEL_WIDTH'(RESET_SELECT);
            clk_gate_q   <= RESET_GATE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            req_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            gate_q       <= gate_d;
            err_q        <= err_d;
            clk_select_q <= clk_select_d;
            clk_gate_q   <= clk_gate_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            req_err_q    <= req_err_d;
        end
    end

    assign REQ_READY  = (state_q == IDLE);
    assign BUSY       = busy_q;
    assign DONE       = done_q;
    assign REQ_ERR    = req_err_q;
    assign CLK_SELECT = clk_select_q;
    assign CLK_GATE   = clk_gate_q;

endmodule

// File: tb/tb_aha_clock_switch_sequencer.sv
// Directed bench for the clock-switch sequencer with a select/gate invariant monitor.
module tb_aha_clock_switch_sequencer;

    localparam int SETTLE = 64;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       REQ_VALID = 1'b0;
    logic       REQ_READY;
    logic [2:0] REQ_SELECT = 3'd0;
    logic       REQ_GATE = 1'b0;
    logic [2:0] CLK_SELECT;
    logic       CLK_GATE;
    logic       BUSY;
    logic       DONE;
    logic       REQ_ERR;

    int checks = 0;
    int errors = 0;

    aha_clock_switch_sequencer #(
        .SEL_WIDTH(3),
        .MAX_SEL(5),
        .SETTLE_CYCLES(SETTLE),
        .RESET_SELECT(0),
        .RESET_GATE(1'b1)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .REQ_VALID (REQ_VALID),
        .REQ_READY (REQ_READY),
        .REQ_SELECT(REQ_SELECT),
        .REQ_GATE  (REQ_GATE),
        .CLK_SELECT(CLK_SELECT),
        .CLK_GATE  (CLK_GATE),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .REQ_ERR   (REQ_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Select may only move while gated, and only after SETTLE gated cycles.
    logic [2:0] prev_sel = 3'd0;
    int         gate_cycles = 0;
    logic       prev_reset = 1'b1;
    always @(posedge CLK) begin
        #1;
        if (!prev_reset && !RESET && (CLK_SELECT !== prev_sel)) begin
            checks++;
            assert ((CLK_GATE === 1'b1) && (gate_cycles >= SETTLE)) else begin
                errors++;
                $error("FAIL invariant select %0d->%0d gate=%0b gated_cycles=%0d required>=%0d",
                       prev_sel, CLK_SELECT, CLK_GATE, gate_cycles, SETTLE);
            end
        end
        gate_cycles = (CLK_GATE === 1'b1) ? gate_cycles + 1 : 0;
        prev_sel    = CLK_SELECT;
        prev_reset  = RESET;
    end

    initial begin
        // Reset state
        repeat (3) step();
        RESET = 1'b0;
        step();
        chk("rst_select", CLK_SELECT, 0);
        chk("rst_gate", CLK_GATE, 1);
        chk("rst_ready", REQ_READY, 1);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_err", REQ_ERR, 0);

        // Full sequence 0 -> 3, ungate at the end
        REQ_VALID = 1'b1; REQ_SELECT = 3'd3; REQ_GATE = 1'b0;
        step();
        REQ_VALID = 1'b0;
        chk("seq_t0_gate", CLK_GATE, 1);
        chk("seq_t0_busy", BUSY, 1);
        chk("seq_t0_ready", REQ_READY, 0);
        for (int k = 1; k <= 127; k++) begin
            step();
            chk($sformatf("seq_gate_k%0d", k), CLK_GATE, 1);
            chk($sformatf("seq_ready_k%0d", k), REQ_READY, 0);
            chk($sformatf("seq_done_k%0d", k), DONE, 0);
            if (k == 63) chk("seq_sel_k63", CLK_SELECT, 0);
            if (k == 64) chk("seq_sel_k64", CLK_SELECT, 3);
        end
        step();
        chk("seq_k128_gate", CLK_GATE, 0);
        chk("seq_k128_done", DONE, 1);
        chk("seq_k128_err", REQ_ERR, 0);
        chk("seq_k128_busy", BUSY, 0);
        chk("seq_k128_ready", REQ_READY, 1);
        chk("seq_k128_sel", CLK_SELECT, 3);
        step();
        chk("seq_k129_done", DONE, 0);

        // Fast path, back to back: select already 3
        REQ_VALID = 1'b1; REQ_SELECT = 3'd3; REQ_GATE = 1'b1;
        step();
        chk("fast1_gate", CLK_GATE, 1);
        chk("fast1_done", DONE, 1);
        chk("fast1_busy", BUSY, 0);
        chk("fast1_ready", REQ_READY, 1);
        REQ_GATE = 1'b0;
        step();
        REQ_VALID = 1'b0;
        chk("fast2_gate", CLK_GATE, 0);
        chk("fast2_done", DONE, 1);
        chk("fast2_busy", BUSY, 0);
        chk("fast2_sel", CLK_SELECT, 3);
        step();
        chk("fast3_done", DONE, 0);

        // Clamped request 7 -> 5, with request noise while busy
        REQ_VALID = 1'b1; REQ_SELECT = 3'd7; REQ_GATE = 1'b1;
        step();
        chk("clamp_t0_gate", CLK_GATE, 1);
        for (int k = 1; k <= 127; k++) begin
            REQ_VALID  = (k <= 120) ? k[0] : 1'b0;
            REQ_SELECT = 3'(k);
            REQ_GATE   = k[1];
            step();
            chk($sformatf("clamp_err_k%0d", k), REQ_ERR, 0);
            if (k == 64) chk("clamp_sel_k64", CLK_SELECT, 5);
            if (k == 100) chk("clamp_busy_k100", BUSY, 1);
        end
        step();
        chk("clamp_k128_done", DONE, 1);
        chk("clamp_k128_err", REQ_ERR, 1);
        chk("clamp_k128_gate", CLK_GATE, 1);
        chk("clamp_k128_sel", CLK_SELECT, 5);
        step();
        chk("clamp_k129_done", DONE, 0);
        chk("clamp_k129_err", REQ_ERR, 0);

        // Clamped onto the current select: fast path with error
        REQ_VALID = 1'b1; REQ_SELECT = 3'd6; REQ_GATE = 1'b0;
        step();
        REQ_VALID = 1'b0;
        chk("fastclamp_done", DONE, 1);
        chk("fastclamp_err", REQ_ERR, 1);
        chk("fastclamp_gate", CLK_GATE, 0);
        chk("fastclamp_busy", BUSY, 0);

        // Reset in the middle of a 5 -> 1 sequence
        REQ_VALID = 1'b1; REQ_SELECT = 3'd1; REQ_GATE = 1'b0;
        step();
        REQ_VALID = 1'b0;
        for (int k = 1; k <= 69; k++) begin
            step();
            if (k == 64) chk("abort_sel_k64", CLK_SELECT, 1);
        end
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        chk("abort_sel", CLK_SELECT, 0);
        chk("abort_gate", CLK_GATE, 1);
        chk("abort_busy", BUSY, 0);
        chk("abort_ready", REQ_READY, 1);
        chk("abort_done", DONE, 0);
        for (int k = 1; k <= 70; k++) begin
            step();
            chk($sformatf("abort_nodone_k%0d", k), DONE, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
